// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small TX queue: host writes are edge-detected, buffered, and sent
// back-to-back as start/data/parity/stop frames on a registered, idle-high serial line.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DATA_BITS-1:0]         data_o_bus,
  output logic                         ready,
  output logic                         busy,
  output logic                         isDone,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         bit_out
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
  localparam int unsigned CW         = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = PW + 1;
  localparam logic [CW-1:0]   BaudLast = CW'(ClksPerBit - 1);
  localparam logic [3:0]      IdxLast  = 4'(DATA_BITS - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  stop_q, stop_d;
  logic                  bit_q, bit_d;
  logic                  enable_d_q;
  logic                  overflow_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];

  logic                  push_req, push, pop, full, empty, done, baud_last, stop_last;
  logic [DATA_BITS-1:0]  head;

  assign push_req  = enable && !enable_d_q;
  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign push      = push_req && !full;
  assign head      = mem[rd_ptr_q];
  assign baud_last = (baud_q == BaudLast);
  assign stop_last = (STOP_BITS == 1) || stop_q;

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_o_bus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_d_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      enable_d_q <= enable;
      if (push_req && full) overflow_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      bit_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    done    = 1'b0;
    bit_d   = 1'b1;
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) state_d = StData;
      end
      StData: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 4'd1;
          if (idx_q == IdxLast) begin
            state_d = (PARITY != 0) ? StParity : StStop;
            stop_d  = 1'b0;
          end
        end
      end
      StParity: begin
        if (baud_last) begin
          state_d = StStop;
          stop_d  = 1'b0;
        end
      end
      StStop: begin
        if (baud_last) begin
          if (stop_last) begin
            done = 1'b1;
            // Chain straight into the next start bit when more characters are queued.
            if (!empty) begin
              pop     = 1'b1;
              state_d = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = ^head;
      idx_d   = '0;
      baud_d  = '0;
    end

    // Line value is registered from the next state so it changes with the state transition.
    case (state_d)
      StStart:  bit_d = 1'b0;
      StData:   bit_d = shift_d[0];
      StParity: bit_d = (PARITY == 2) ? par_d : ~par_d;
      default:  bit_d = 1'b1;
    endcase
  end

  assign ready      = !full;
  assign busy       = (state_q != StIdle);
  assign isDone     = done;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign bit_out    = bit_q;

endmodule
